lagline_fetch_sequencer: RTL and testbench

Per-scanline scheduler for the shared char ROM port. On each line-start strobe it snapshots the 20-digit BCD lag counters and the lag-display template row. It then issues one char ROM address per cycle and merges the returned glyph rows into a working line buffer. When the line is complete it publishes the buffer atomically to the pixel path. It replaces hand-placed counterX-slot fetches with a latency-parameterised, self-timed sequence.

---
 rtl/lagline_fetch_sequencer.sv | 170 +++++++++++++++++
 tb/tb_lagline_fetch_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lagline_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// lagline_fetch_sequencer
//
// Per-scanline scheduler for the shared char ROM port. A line-start strobe
// snapshots the BCD lag counters, the glyph row and the lag-display template
// row. One char ROM address is then issued per cycle, one for each digit.
// The glyph rows that come back are merged into a working copy of the template.
// When the last glyph row has landed, the whole buffer is published to the
// pixel path in a single cycle.
//
// Ports
//   clock          in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   start          in   line-start strobe, sampled every cycle
//   row            in   glyph row for this line
//   bcdcount       in   packed BCD digits, digit k = bcdcount[4k+3:4k]
//   template_line  in   static lag-display row
//   char_addr      out  char ROM address (registered)
//   char_data      in   char ROM glyph row, ROM_LATENCY cycles after address
//   line_out       out  published line
//   busy           out  sequence in progress
//   done           out  one-cycle pulse, line_out updated this cycle
//   overrun        out  one-cycle pulse, start seen while not idle
//   dbg_state      out  current FSM state (0 idle, 1 fetch, 2 drain, 3 publish)
//
// Handshake: there is no back-pressure. A start pulse in IDLE always
// launches a sequence. Any start pulse outside IDLE is dropped and flagged on
// overrun. The ROM is a fixed-latency slave with no valid or ready signals.
// ---------------------------------------------------------------------------
module lagline_fetch_sequencer #(
  parameter int          DIGITS      = 20,
  parameter int          ROM_LATENCY = 2,
  parameter int          LINE_WIDTH  = 280,
  parameter logic [7:0]  CHAR_BASE   = 8'h30
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [3:0]              row,
  input  logic [4*DIGITS-1:0]     bcdcount,
  input  logic [LINE_WIDTH-1:0]   template_line,
  output logic [10:0]             char_addr,
  input  logic [7:0]              char_data,
  output logic [LINE_WIDTH-1:0]   line_out,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun,
  output logic [1:0]              dbg_state
);

  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam int OW = $clog2(LINE_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_PUBLISH = 2'd3
  } state_t;

  state_t                  r_state;
  logic [KW-1:0]           r_k;        // next digit to issue
  logic [KW-1:0]           r_cap;      // next digit to capture
  logic [DW-1:0]           r_drain;
  logic [ROM_LATENCY-1:0]  r_pipe;     // one bit per address in flight
  logic [4*DIGITS-1:0]     r_bcd;
  logic [3:0]              r_row;
  logic [LINE_WIDTH-1:0]   r_buf;

  logic [3:0]              w_digit;
  logic [10:0]             w_addr;
  logic [OW-1:0]           w_off;
  logic                    w_capture;

  // Bit offset of digit k in the line. Each group of five digits sits in a
  // 56-bit field. Group 0 is the leftmost field in the line. Slot 2 skips
  // 8 bits, which leaves room for the template's decimal-point glyph.
  function automatic int slot_off(input int k);
    int g;
    int s;
    int so;
    g = k / 5;
    s = k % 5;
    case (s)
      0:       so = 0;
      1:       so = 8;
      2:       so = 24;
      3:       so = 32;
      default: so = 40;
    endcase
    return 24 + 56 * (3 - g) + so;
  endfunction

  assign w_digit   = r_bcd[{r_k, 2'b00} +: 4];
  // The result is 11 bits wide and any carry out is dropped. Digits above 9
  // are used as they are.
  assign w_addr    = ((11'(CHAR_BASE) + 11'(w_digit)) << 4) + 11'(r_row);
  assign w_off     = OW'(slot_off(int'(r_cap)));
  // An address issued at one edge is captured ROM_LATENCY edges later. At
  // that point its marker bit has reached the top of r_pipe.
  assign w_capture = r_pipe[ROM_LATENCY-1];
  assign dbg_state = r_state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_k       <= '0;
      r_cap     <= '0;
      r_drain   <= '0;
      r_pipe    <= '0;
      r_bcd     <= '0;
      r_row     <= '0;
      r_buf     <= '0;
      char_addr <= '0;
      line_out  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= start && (r_state != ST_IDLE);
      r_pipe  <= (r_pipe << 1) | ROM_LATENCY'(r_state == ST_FETCH);

      if (w_capture) begin
        r_buf[w_off +: 8] <= char_data;
        r_cap             <= r_cap + KW'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_bcd   <= bcdcount;
            r_row   <= row;
            r_buf   <= template_line;
            r_k     <= '0;
            r_cap   <= '0;
            busy    <= 1'b1;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          char_addr <= w_addr;
          if (r_k == KW'(DIGITS - 1)) begin
            r_drain <= DW'(ROM_LATENCY - 1);
            r_state <= ST_DRAIN;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        ST_DRAIN: begin
          // The final capture happens on the edge that leaves DRAIN.
          if (r_drain == '0) begin
            r_state <= ST_PUBLISH;
          end else begin
            r_drain <= r_drain - DW'(1);
          end
        end
        ST_PUBLISH: begin
          line_out <= r_buf;
          done     <= 1'b1;
          busy     <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lagline_fetch_sequencer.sv
module tb_lagline_fetch_sequencer;

  localparam int LW = 280;

  logic            clock;
  logic            reset_n;
  logic            start;
  logic            start3;
  logic [3:0]      row;
  logic [79:0]     bcdcount;
  logic [LW-1:0]   template_line;
  logic [10:0]     char_addr, char_addr3;
  logic [7:0]      char_data, char_data3;
  logic [LW-1:0]   line_out, line_out3;
  logic            busy, busy3, done, done3, overrun, overrun3;
  logic [1:0]      dbg_state, dbg_state3;

  int total = 0;
  int bad   = 0;
  int rom_mode = 0;

  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] exp3_q[$];
  logic [10:0]   addr_q[$];

  int off_tab [20] = '{192, 200, 216, 224, 232, 136, 144, 160, 168, 176,
                       80, 88, 104, 112, 120, 24, 32, 48, 56, 64};

  typedef struct {
    logic [79:0]   bcd;
    logic [3:0]    row;
    logic [LW-1:0] tmpl;
    int            mode;
    logic [10:0]   exp_addr0;
    logic [LW-1:0] exp_line;
  } vec_t;

  vec_t vecs [5];

  lagline_fetch_sequencer dut (
    .clock(clock), .reset_n(reset_n), .start(start), .row(row),
    .bcdcount(bcdcount), .template_line(template_line),
    .char_addr(char_addr), .char_data(char_data), .line_out(line_out),
    .busy(busy), .done(done), .overrun(overrun), .dbg_state(dbg_state)
  );

  lagline_fetch_sequencer #(.ROM_LATENCY(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .start(start3), .row(row),
    .bcdcount(bcdcount), .template_line(template_line),
    .char_addr(char_addr3), .char_data(char_data3), .line_out(line_out3),
    .busy(busy3), .done(done3), .overrun(overrun3), .dbg_state(dbg_state3)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- ROM models ----------------
  function automatic logic [7:0] rom_q(input logic [10:0] a, input int mode);
    case (mode)
      0:       return a[7:0];
      1:       return 8'h00;
      2:       return a[7:0] ^ 8'hA5;
      default: return a[7:0] ^ {a[3:0], a[7:4]};
    endcase
  endfunction

  logic [10:0] rom_d1, rom3_d1, rom3_d2;
  always_ff @(posedge clock) begin
    rom_d1  <= char_addr;
    rom3_d1 <= char_addr3;
    rom3_d2 <= rom3_d1;
  end
  assign char_data  = rom_q(rom_d1, rom_mode);
  assign char_data3 = rom_q(rom3_d2, rom_mode);

  // ---------------- reference model ----------------
  function automatic logic [10:0] model_addr(input logic [3:0] d, input logic [3:0] r);
    int v;
    v = (48 + int'(d)) * 16 + int'(r);
    return v[10:0];
  endfunction

  function automatic logic [LW-1:0] model_line(input logic [79:0] bcd, input logic [3:0] r,
                                               input logic [LW-1:0] tmpl, input int mode);
    logic [LW-1:0] l;
    l = tmpl;
    for (int k = 0; k < 20; k++) begin
      l[off_tab[k] +: 8] = rom_q(model_addr(bcd[4*k +: 4], r), mode);
    end
    return l;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every done must match the oldest expected line.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("line_out", line_out, exp_q.pop_front());
    end
    if (done3 === 1'b1) begin
      if (exp3_q.size() == 0) chk("unexpected_done3", 1, 0);
      else chk("line_out3", line_out3, exp3_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input logic [79:0] b, input logic [3:0] r,
                            input logic [LW-1:0] t, input int m);
    bcdcount      = b;
    row           = r;
    template_line = t;
    rom_mode      = m;
  endtask

  // Runs one full line on the main DUT, checking the address stream and the
  // done latency. The scoreboard monitor checks the published line.
  task automatic run_line(input logic [LW-1:0] exp_line, input logic [10:0] exp_addr0,
                          input bit check_addr0);
    logic [LW-1:0] prev;
    int c;
    bit got;
    exp_q.push_back(exp_line);
    for (int k = 0; k < 20; k++) addr_q.push_back(model_addr(bcdcount[4*k +: 4], row));
    prev  = line_out;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("busy_e0", busy, 1);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      chk("char_addr", char_addr, addr_q.pop_front());
      if (i == 1 && check_addr0) chk("char_addr0", char_addr, exp_addr0);
    end
    // The bench changes inputs here; the snapshot must ignore the change.
    bcdcount      = ~bcdcount;
    row           = ~row;
    template_line = ~template_line;
    chk("line_stable_mid", line_out, prev);
    c   = 20;
    got = 0;
    while (c < 60 && !got) begin
      @(posedge clock); #1;
      c++;
      if (c == 22) chk("busy_e22", busy, 1);
      if (done) got = 1;
    end
    chk("done_seen", got, 1);
    chk("done_latency", c, 23);
    chk("busy_at_done", busy, 0);
    @(posedge clock); #1;
    chk("done_pulse_width", done, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [LW-1:0] t;
    logic [LW-1:0] e;
    logic [79:0]   b;
    int c;
    bit got;

    vecs[0] = '{80'h12345, 4'h5, '0, 0, 11'h355, '0};
    vecs[1] = '{80'h0, 4'h7, '1, 1, 11'h307, '0};
    vecs[2] = '{80'hA, 4'h0, '0, 0, 11'h3A0, '0};
    vecs[3] = '{80'h98765432100123456789, 4'hF, '1, 2, 11'h39F, '0};
    vecs[4] = '{{20{4'hF}}, 4'h3, '0, 3, 11'h3F3, '0};
    for (int i = 0; i < 5; i++)
      vecs[i].exp_line = model_line(vecs[i].bcd, vecs[i].row, vecs[i].tmpl, vecs[i].mode);

    reset_n = 1'b0;
    start   = 1'b0;
    start3  = 1'b0;
    set_inputs('0, '0, '0, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_char_addr", char_addr, 0);
    chk("rst_line_out", line_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Table-driven lines.
    for (int i = 0; i < 5; i++) begin
      set_inputs(vecs[i].bcd, vecs[i].row, vecs[i].tmpl, vecs[i].mode);
      run_line(vecs[i].exp_line, vecs[i].exp_addr0, 1);
      if (i == 0) begin
        chk("t1_slot192", line_out[199:192], 8'h55);
        chk("t1_slot200", line_out[207:200], 8'h45);
        chk("t1_slot216", line_out[223:216], 8'h35);
        chk("t1_slot224", line_out[231:224], 8'h25);
        chk("t1_slot232", line_out[239:232], 8'h15);
        chk("t1_dp208", line_out[215:208], 8'h00);
      end
      if (i == 1) begin
        chk("t2_ones", $countones(line_out), 120);
        chk("t2_dp208", line_out[215:208], 8'hFF);
      end
    end

    // Random lines.
    for (int r = 0; r < 3; r++) begin
      t = '0;
      for (int w = 0; w < 9; w++) t = {t[LW-33:0], 32'($urandom)};
      b = {16'($urandom), 32'($urandom), 32'($urandom)};
      set_inputs(b, 4'($urandom_range(0, 15)), t, $urandom_range(0, 3));
      run_line(model_line(bcdcount, row, template_line, rom_mode), '0, 0);
    end

    // Start at E0 and E5, then at E23 (overrun) and E24 (accepted).
    set_inputs(80'h31415926535897932384, 4'h9, {35{8'h5A}}, 2);
    e = model_line(bcdcount, row, template_line, rom_mode);
    exp_q.push_back(e);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int cc = 1; cc <= 48; cc++) begin
      start = (cc == 5 || cc == 23 || cc == 24);
      if (cc == 24) exp_q.push_back(e);
      @(posedge clock); #1;
      start = 1'b0;
      chk("seq_overrun", overrun, (cc == 5 || cc == 23));
      chk("seq_done", done, (cc == 23 || cc == 47));
      chk("seq_busy", busy, (cc <= 22 || (cc >= 24 && cc <= 46)));
    end

    // Reset in the middle of a sequence.
    set_inputs(80'h55555, 4'h2, '0, 0);
    exp_q.push_back(model_line(bcdcount, row, template_line, rom_mode));
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_line_out", line_out, 0);
    chk("arst_char_addr", char_addr, 0);
    chk("arst_state", dbg_state, 0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (30) @(posedge clock);
    #1;
    chk("post_rst_idle", busy, 0);
    chk("post_rst_line", line_out, 0);
    set_inputs(vecs[0].bcd, vecs[0].row, vecs[0].tmpl, vecs[0].mode);
    run_line(vecs[0].exp_line, vecs[0].exp_addr0, 1);

    // ROM_LATENCY=3 build with the same stimulus as the first vector.
    set_inputs(vecs[0].bcd, vecs[0].row, vecs[0].tmpl, vecs[0].mode);
    exp3_q.push_back(vecs[0].exp_line);
    start3 = 1'b1;
    @(posedge clock); #1;
    start3 = 1'b0;
    c   = 0;
    got = 0;
    while (c < 60 && !got) begin
      @(posedge clock); #1;
      c++;
      if (done3) got = 1;
    end
    chk("l3_done_seen", got, 1);
    chk("l3_done_latency", c, 24);
    chk("l3_same_line", line_out3, vecs[0].exp_line);

    repeat (3) @(posedge clock);
    #1;
    chk("sb_empty", exp_q.size() + exp3_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
